// File: rtl/clb_pkg.sv
// clb_pkg: LE configuration layout shared by clb_lut_array and clb_le; `define CLB_CARRY_EN adds the CMODE bit.
package clb_pkg;
  localparam int OFS_LUT = 0;
  // control-bit offsets are counted from the top of the LUT field
  localparam int OFS_OSEL = 0;
  localparam int OFS_INIT = 1;
  localparam int OFS_FBSEL = 2;
  localparam int OFS_CMODE = 3;
`ifdef CLB_CARRY_EN
  localparam int CTL_W = 4;
  typedef struct packed {
    logic cmode;
    logic fbsel;
    logic init;
    logic osel;
  } le_cfg_t;
`else
  localparam int CTL_W = 3;
  typedef struct packed {
    logic fbsel;
    logic init;
    logic osel;
  } le_cfg_t;
`endif
  function automatic int le_cfg_w(input int lut_k);
    return (1 << lut_k) + CTL_W;
  endfunction
endpackage

// File: rtl/clb_le.sv
// clb_le: one logic element - LUT, Q feedback mux, D register, output mux; carry logic with CLB_CARRY_EN.
module clb_le
  import clb_pkg::*;
#(
  parameter int LUT_K = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         cfg_done,
  input  logic                         cfg_en,
  input  logic                         done_rise,
  input  logic                         init_ld,
  input  logic [le_cfg_w(LUT_K)-1:0]   cfg,
  input  logic [LUT_K-1:0]             in_bits,
`ifdef CLB_CARRY_EN
  input  logic                         cin,
  output logic                         cout,
`endif
  output logic                         out,
  output logic                         q
);
  localparam int LUT_N = 1 << LUT_K;
  le_cfg_t ctl;
  logic [LUT_N-1:0] lut;
  logic [LUT_K-1:0] a;
  logic f;
  assign lut = cfg[OFS_LUT +: LUT_N];
  assign ctl = le_cfg_t'(cfg[LUT_N +: CTL_W]);
  assign a = ctl.fbsel ? {in_bits[LUT_K-1:1], q} : in_bits;
`ifdef CLB_CARRY_EN
  logic [1:0] g;
  // g = {a[2], a[1]}; a[2] reads as 0 when LUT_K is 2
  assign g = 2'(a >> 1);
  assign f = lut[a] ^ (ctl.cmode & cin);
  assign cout = ctl.cmode ? (g[0] & g[1]) | (cin & (g[0] | g[1])) : cin;
`else
  assign f = lut[a];
`endif
  assign out = cfg_done & (ctl.osel ? q : f);
  always_ff @(posedge clk)
    if (rst) q <= 1'b0;
    else if (done_rise) q <= init_ld;
    else if (cfg_done && !cfg_en && ce) q <= f;
endmodule

// File: rtl/clb_lut_array.sv
// clb_lut_array: NUM_LE LUT_K-input LEs behind a serial config chain with a done flag.
// `define CLB_CARRY_EN adds the CIN/COUT carry chain and a per-LE CMODE bit.
module clb_lut_array
  import clb_pkg::*;
#(
  parameter int LUT_K  = 4,
  parameter int NUM_LE = 2
) (
  input  logic                    K,
  input  logic                    RST,
  input  logic                    CE,
  input  logic [NUM_LE*LUT_K-1:0] IN,
  output logic [NUM_LE-1:0]       OUT,
  output logic [NUM_LE-1:0]       QOUT,
  input  logic                    CFG_EN,
  input  logic                    CFG_DIN,
  output logic                    CFG_DOUT,
  output logic                    CFG_DONE
`ifdef CLB_CARRY_EN
  ,
  input  logic                    CIN,
  output logic                    COUT
`endif
);
  localparam int LUT_N = 1 << LUT_K;
  localparam int LE_W = le_cfg_w(LUT_K);
  localparam int CFG_BITS = NUM_LE * LE_W;
  localparam int CW = $clog2(CFG_BITS + 1);
  logic [CFG_BITS-1:0] chain, chain_nxt;
  logic [CW-1:0] cnt;
  logic done_rise;
`ifdef CLB_CARRY_EN
  logic [NUM_LE:0] c;
  assign c[0] = CIN;
  assign COUT = c[NUM_LE];
`endif
  assign chain_nxt = {chain[CFG_BITS-2:0], CFG_DIN};
  assign done_rise = CFG_EN & ~CFG_DONE & (cnt == CW'(CFG_BITS - 1));
  assign CFG_DOUT = chain[CFG_BITS-1];
  always_ff @(posedge K)
    if (RST) begin
      chain <= '0;
      cnt <= '0;
      CFG_DONE <= 1'b0;
    end else if (CFG_EN) begin
      chain <= chain_nxt;
      cnt <= (cnt == CW'(CFG_BITS)) ? cnt : cnt + 1'b1;
      CFG_DONE <= CFG_DONE | done_rise;
    end
  // INIT comes from the post-shift chain so the final bit's config is what gets loaded
  for (genvar i = 0; i < NUM_LE; i++) begin : g_le
    clb_le #(.LUT_K(LUT_K)) u_le (
      .clk      (K),
      .rst      (RST),
      .ce       (CE),
      .cfg_done (CFG_DONE),
      .cfg_en   (CFG_EN),
      .done_rise(done_rise),
      .init_ld  (chain_nxt[i*LE_W + LUT_N + OFS_INIT]),
      .cfg      (chain[i*LE_W +: LE_W]),
      .in_bits  (IN[i*LUT_K +: LUT_K]),
`ifdef CLB_CARRY_EN
      .cin      (c[i]),
      .cout     (c[i+1]),
`endif
      .out      (OUT[i]),
      .q        (QOUT[i])
    );
  end
endmodule

// File: tb/tb_clb_lut_array.sv
// tb_clb_lut_array: table vectors, corner sequences and random traffic against a bit-history model of the CLB.
module tb_clb_lut_array;
`ifdef CLB_CARRY_EN
  localparam int LW = 20;
`else
  localparam int LW = 19;
`endif
  localparam int CB = 2 * LW;
  logic K = 0, RST = 0, CE = 0, CFG_EN = 0, CFG_DIN = 0;
  logic [7:0] IN = 0;
  logic [1:0] OUT, QOUT;
  logic CFG_DOUT, CFG_DONE;
`ifdef CLB_CARRY_EN
  logic CIN = 0, COUT;
`endif
  clb_lut_array #(.LUT_K(4), .NUM_LE(2)) dut (
    .K(K), .RST(RST), .CE(CE), .IN(IN), .OUT(OUT), .QOUT(QOUT),
    .CFG_EN(CFG_EN), .CFG_DIN(CFG_DIN), .CFG_DOUT(CFG_DOUT), .CFG_DONE(CFG_DONE)
`ifdef CLB_CARRY_EN
    , .CIN(CIN), .COUT(COUT)
`endif
  );
  always #5 K = ~K;

  int checks = 0, errors = 0;
  // model: every shifted bit kept in order; chain position p holds the bit shifted p shifts ago
  bit hist[$];
  int mcnt = 0;
  bit mdone = 0;
  bit [1:0] mq = 0;

  typedef struct {bit rst, en, din, ce; logic [7:0] inp; logic [1:0] out, qout; bit done;} vec_t;
  vec_t rv[4], tv[10];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cb(int p);
    if (p < hist.size()) return hist[hist.size()-1-p];
    return 1'b0;
  endfunction

  function automatic bit cin_v();
`ifdef CLB_CARRY_EN
    return CIN;
`else
    return 1'b0;
`endif
  endfunction

  // returns {carry out of LE1, F1, F0}
  function automatic logic [2:0] mcomb(logic [7:0] inp, bit cin);
    logic [2:0] r;
    bit c;
    int a;
    c = cin;
    for (int i = 0; i < 2; i++) begin
      a = int'(inp[4*i +: 4]);
      if (cb(i*LW + 18)) a = (a & 14) | int'(mq[i]);
      r[i] = cb(i*LW + a);
      if (LW > 19 && cb(i*LW + 19)) begin
        r[i] = r[i] ^ c;
        c = (((a >> 1) & 1) + ((a >> 2) & 1) + int'(c)) >= 2;
      end
    end
    r[2] = c;
    return r;
  endfunction

  function automatic logic [1:0] eout(logic [2:0] r);
    logic [1:0] o;
    for (int i = 0; i < 2; i++) o[i] = mdone ? (cb(i*LW + 16) ? mq[i] : r[i]) : 1'b0;
    return o;
  endfunction

  function automatic logic [63:0] le(int i, logic [15:0] lut, bit osel, bit init, bit fb, bit cm);
    logic [63:0] w;
    w = 64'(lut) | (64'(osel) << 16) | (64'(init) << 17) | (64'(fb) << 18);
    if (LW > 19) w = w | (64'(cm) << 19);
    return w << (i * LW);
  endfunction

  task automatic mupd();
    logic [2:0] r;
    r = mcomb(IN, cin_v());
    if (RST) begin
      hist.delete();
      mcnt = 0;
      mdone = 0;
      mq = 0;
    end else begin
      if (CFG_EN) begin
        hist.push_back(CFG_DIN);
        if (hist.size() > CB) void'(hist.pop_front());
        if (mcnt < CB) mcnt++;
      end
      if (!mdone && mcnt == CB) begin
        mdone = 1;
        mq = {cb(LW + 17), cb(17)};
      end else if (mdone && !CFG_EN && CE) mq = r[1:0];
    end
  endtask

  task automatic drive(bit rst, bit en, bit din, bit ce, logic [7:0] inp);
    logic [2:0] r;
    RST = rst; CFG_EN = en; CFG_DIN = din; CE = ce; IN = inp;
    #1;
    r = mcomb(IN, cin_v());
    chk("m_out", 32'(OUT), 32'(eout(r)));
    chk("m_qout", 32'(QOUT), 32'(mq));
    chk("m_done", 32'(CFG_DONE), 32'(mdone));
    chk("m_dout", 32'(CFG_DOUT), 32'(cb(CB-1)));
`ifdef CLB_CARRY_EN
    chk("m_cout", 32'(COUT), 32'(r[2]));
`endif
  endtask

  task automatic tick();
    @(posedge K);
    mupd();
    @(negedge K);
  endtask

  task automatic shift_bits(logic [63:0] cfg, int hi, int lo);
    for (int j = hi; j >= lo; j--) begin
      drive(0, 1, cfg[j], 0, 8'($urandom));
      tick();
    end
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 8'($urandom));
    tick();
  endtask

  initial begin
    logic [63:0] cfg_a, cfg_b, rc;
    logic [7:0] pat;
    bit din;
    cfg_a = le(0, 16'h8000, 0, 0, 0, 0) | le(1, 16'hAAAA, 1, 1, 0, 0);
    cfg_b = le(0, 16'h5555, 0, 0, 1, 0);
    pat = 8'b1011_0010;
    rv[0] = '{1, 0, 0, 0, 8'hFF, 2'b00, 2'b00, 0};
    rv[1] = '{1, 1, 1, 1, 8'hA5, 2'b00, 2'b00, 0};
    rv[2] = '{0, 0, 0, 1, 8'h3C, 2'b00, 2'b00, 0};
    rv[3] = '{0, 0, 0, 1, 8'hFF, 2'b00, 2'b00, 0};
    tv[0] = '{0, 0, 0, 0, 8'h0F, 2'b11, 2'b10, 1};
    tv[1] = '{0, 0, 0, 0, 8'h0E, 2'b10, 2'b10, 1};
    tv[2] = '{0, 0, 0, 1, 8'h0F, 2'b11, 2'b10, 1};
    tv[3] = '{0, 0, 0, 0, 8'h00, 2'b00, 2'b01, 1};
    tv[4] = '{0, 0, 0, 0, 8'h10, 2'b00, 2'b01, 1};
    tv[5] = '{0, 0, 0, 0, 8'hF0, 2'b00, 2'b01, 1};
    tv[6] = '{0, 0, 0, 0, 8'h1E, 2'b00, 2'b01, 1};
    tv[7] = '{0, 0, 0, 0, 8'h00, 2'b00, 2'b01, 1};
    tv[8] = '{0, 0, 0, 1, 8'h1F, 2'b01, 2'b01, 1};
    tv[9] = '{0, 0, 0, 0, 8'h00, 2'b10, 2'b11, 1};

    // bring registers out of X before any comparison
    @(negedge K);
    RST = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(rv[i].rst, rv[i].en, rv[i].din, rv[i].ce, rv[i].inp);
      chk("rst_out", 32'(OUT), 32'(rv[i].out));
      chk("rst_qout", 32'(QOUT), 32'(rv[i].qout));
      chk("rst_done", 32'(CFG_DONE), 32'(rv[i].done));
      chk("rst_dout", 32'(CFG_DOUT), 0);
      tick();
    end

    do_reset();
    shift_bits(cfg_a, CB-1, 1);
    drive(0, 1, cfg_a[0], 0, 8'h00);
    chk("done_pre", 32'(CFG_DONE), 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].rst, tv[i].en, tv[i].din, tv[i].ce, tv[i].inp);
      chk("tab_out", 32'(OUT), 32'(tv[i].out));
      chk("tab_qout", 32'(QOUT), 32'(tv[i].qout));
      chk("tab_done", 32'(CFG_DONE), 32'(tv[i].done));
      tick();
    end

    do_reset();
    shift_bits(cfg_b, CB-1, 0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 1, 8'($urandom));
      chk("div2", 32'(QOUT[0]), 32'(k & 1));
      tick();
    end

    do_reset();
    shift_bits(cfg_a, CB-1, CB-10);
    drive(1, 1, 1, 0, 8'h00);
    tick();
    shift_bits(cfg_a, CB-1, 1);
    drive(0, 0, 0, 0, 8'h00);
    chk("rst_mid_done0", 32'(CFG_DONE), 0);
    shift_bits(cfg_a, 0, 0);
    drive(0, 0, 0, 0, 8'h00);
    chk("rst_mid_done1", 32'(CFG_DONE), 1);
    tick();

    do_reset();
    for (int n = 1; n <= 46; n++) begin
      din = (n <= 8) ? pat[8-n] : 1'($urandom);
      drive(0, 1, din, 0, 8'($urandom));
      if (n >= 39) chk("dout_seq", 32'(CFG_DOUT), 32'(pat[7-(n-39)]));
      tick();
    end

`ifdef CLB_CARRY_EN
    do_reset();
    shift_bits(le(0, 16'h3C3C, 0, 0, 0, 1) | le(1, 16'h3C3C, 0, 0, 0, 1), CB-1, 0);
    CIN = 0;
    drive(0, 0, 0, 0, 8'h26);
    chk("add_out", 32'(OUT), 0);
    chk("add_cout", 32'(COUT), 1);
    CIN = 1;
    drive(0, 0, 0, 0, 8'h06);
    chk("add_out_c", 32'(OUT), 3);
    chk("add_cout_c", 32'(COUT), 0);
    tick();
`endif

    do_reset();
    rc = {$urandom, $urandom};
    shift_bits(rc, CB-1, 0);
    for (int n = 0; n < 1500; n++) begin
`ifdef CLB_CARRY_EN
      CIN = 1'($urandom);
`endif
      drive($urandom_range(99) == 0, $urandom_range(7) == 0, 1'($urandom), 1'($urandom), 8'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
